// File: rtl/x4xx_dio_pulse_gen_pkg.sv
// x4xx DIO pulse generator: register map, bit positions, constants.
// Shared by the channel, the top and the bench.
package x4xx_dio_pulse_gen_pkg;

  localparam logic [19:0] REG_CONTROL  = 20'h00;
  localparam logic [19:0] REG_STATUS   = 20'h04;
  localparam logic [19:0] REG_MASK     = 20'h08;
  localparam logic [19:0] REG_PERIOD_A = 20'h0C;
  localparam logic [19:0] REG_HIGH_A   = 20'h10;
  localparam logic [19:0] REG_COUNT_A  = 20'h14;
  localparam logic [19:0] REG_PERIOD_B = 20'h18;
  localparam logic [19:0] REG_HIGH_B   = 20'h1C;
  localparam logic [19:0] REG_COUNT_B  = 20'h20;

  localparam int START_A_BIT = 0;
  localparam int STOP_A_BIT  = 1;
  localparam int ARM_A_BIT   = 2;
  localparam int START_B_BIT = 16;
  localparam int STOP_B_BIT  = 17;
  localparam int ARM_B_BIT   = 18;

  localparam int BUSY_A_BIT  = 0;
  localparam int DONE_A_BIT  = 1;
  localparam int ARMED_A_BIT = 2;
  localparam int BUSY_B_BIT  = 16;
  localparam int DONE_B_BIT  = 17;
  localparam int ARMED_B_BIT = 18;

  localparam int MASK_A_LSB = 0;
  localparam int MASK_A_MSB = 11;
  localparam int MASK_B_LSB = 16;
  localparam int MASK_B_MSB = 27;

  localparam int PERIOD_MIN = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } chan_state_t;

endpackage

// File: rtl/x4xx_dio_pulse_gen_if.sv
// x4xx DIO pulse generator: ctrlport request/response bundle.
// Master drives requests, slave returns a one-cycle ack with data.
interface x4xx_dio_pulse_gen_if;
  logic        req_wr;
  logic        req_rd;
  logic [19:0] req_addr;
  logic [31:0] req_data;
  logic        resp_ack;
  logic [31:0] resp_data;

  modport master (
    output req_wr, req_rd, req_addr, req_data,
    input  resp_ack, resp_data
  );

  modport slave (
    input  req_wr, req_rd, req_addr, req_data,
    output resp_ack, resp_data
  );
endinterface

// File: rtl/x4xx_dio_pulse_chan.sv
// x4xx DIO pulse generator: one channel (FSM, shadows, counters).
// Arm/trigger inputs are tied low when DIO_PULSE_GEN_TRIG_EN is off.
module x4xx_dio_pulse_chan
  import x4xx_dio_pulse_gen_pkg::*;
#(
  parameter int DIO_WIDTH = 12,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic                 i_arm,
  input  logic                 i_trig,
  input  logic [CNT_W-1:0]     i_period,
  input  logic [CNT_W-1:0]     i_high,
  input  logic [CNT_W-1:0]     i_count,
  input  logic [DIO_WIDTH-1:0] i_mask,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_armed,
  output logic [DIO_WIDTH-1:0] o_gpio
);

  chan_state_t r_state, w_state_nxt;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_per;
  logic [CNT_W-1:0] r_sh_per;
  logic [CNT_W-1:0] r_sh_high;
  logic [CNT_W-1:0] r_sh_count;
  logic             r_done;
  logic             r_armed;
  logic [DIO_WIDTH-1:0] r_gpio;

  logic [CNT_W-1:0] w_p;
  logic [CNT_W-1:0] w_per_inc;
  logic w_run, w_go, w_wrap, w_last, w_high;

  assign w_run     = (r_state == ST_RUN);
  assign w_go      = i_start | (i_trig & r_armed & ~w_run);
  assign w_p       = (r_sh_per < CNT_W'(PERIOD_MIN)) ?
                     CNT_W'(PERIOD_MIN) : r_sh_per;
  assign w_wrap    = (r_cnt == w_p - 1'b1);
  assign w_per_inc = r_per + 1'b1;
  assign w_last    = w_wrap && (r_sh_count != '0) &&
                     (w_per_inc == r_sh_count);
  assign w_high    = w_run && (r_cnt < r_sh_high);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: stop beats start, start restarts a running channel.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_go && !i_stop) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (i_stop)      w_state_nxt = ST_IDLE;
        else if (w_go)   w_state_nxt = ST_RUN;
        else if (w_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Counters, shadows reloaded at each period boundary, done/armed flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_per      <= '0;
      r_sh_per   <= '0;
      r_sh_high  <= '0;
      r_sh_count <= '0;
      r_done     <= 1'b0;
      r_armed    <= 1'b0;
    end else if (i_stop) begin
      r_armed <= 1'b0;
    end else if (w_go) begin
      r_cnt      <= '0;
      r_per      <= '0;
      r_sh_per   <= i_period;
      r_sh_high  <= i_high;
      r_sh_count <= i_count;
      r_done     <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      if (i_arm) r_armed <= 1'b1;
      if (w_run) begin
        if (w_wrap) begin
          r_cnt      <= '0;
          r_per      <= (&r_per) ? r_per : w_per_inc;
          r_sh_per   <= i_period;
          r_sh_high  <= i_high;
          r_sh_count <= i_count;
          if (w_last) r_done <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  // Registered waveform; mask is applied live.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_gpio <= '0;
    else        r_gpio <= i_mask & {DIO_WIDTH{w_high}};
  end

  assign o_busy  = w_run;
  assign o_done  = r_done;
  assign o_armed = r_armed;
  assign o_gpio  = r_gpio;

endmodule

// File: rtl/x4xx_dio_pulse_gen.sv
// x4xx DIO pulse generator top: ctrlport regs and two channels.
// Define DIO_PULSE_GEN_TRIG_EN to add trig_in and ARM/ARMED bits.
module x4xx_dio_pulse_gen
  import x4xx_dio_pulse_gen_pkg::*;
#(
  parameter int REG_BASE  = 0,
  parameter int DIO_WIDTH = 12,
  parameter int CNT_W     = 32
) (
  input  logic                 ctrlport_clk,
  input  logic                 ctrlport_rst_n,
  x4xx_dio_pulse_gen_if.slave  s_ctrlport,
`ifdef DIO_PULSE_GEN_TRIG_EN
  input  logic                 trig_in,
`endif
  output logic [DIO_WIDTH-1:0] gpio_out_fabric_a,
  output logic [DIO_WIDTH-1:0] gpio_out_fabric_b,
  output logic [1:0]           busy
);

  logic [DIO_WIDTH-1:0] r_mask_a, r_mask_b;
  logic [CNT_W-1:0] r_period_a, r_high_a, r_count_a;
  logic [CNT_W-1:0] r_period_b, r_high_b, r_count_b;
  logic        r_ack;
  logic [31:0] r_rdata;

  logic [19:0] w_off;
  logic        w_hit;
  logic [31:0] w_rdata;
  logic        w_ctl;
  logic        w_start_a, w_stop_a, w_arm_a;
  logic        w_start_b, w_stop_b, w_arm_b;
  logic        w_trig;
  logic        w_busy_a, w_done_a, w_armed_a;
  logic        w_busy_b, w_done_b, w_armed_b;

  assign w_off = s_ctrlport.req_addr - 20'(REG_BASE);
  assign w_ctl = s_ctrlport.req_wr && (w_off == REG_CONTROL);

  assign w_start_a = w_ctl & s_ctrlport.req_data[START_A_BIT];
  assign w_stop_a  = w_ctl & s_ctrlport.req_data[STOP_A_BIT];
  assign w_start_b = w_ctl & s_ctrlport.req_data[START_B_BIT];
  assign w_stop_b  = w_ctl & s_ctrlport.req_data[STOP_B_BIT];

`ifdef DIO_PULSE_GEN_TRIG_EN
  assign w_arm_a = w_ctl & s_ctrlport.req_data[ARM_A_BIT];
  assign w_arm_b = w_ctl & s_ctrlport.req_data[ARM_B_BIT];
  assign w_trig  = trig_in;
`else
  assign w_arm_a = 1'b0;
  assign w_arm_b = 1'b0;
  assign w_trig  = 1'b0;
`endif

  // Address decode and read mux; unused bits read zero.
  always_comb begin
    w_hit   = 1'b0;
    w_rdata = '0;
    case (w_off)
      REG_CONTROL: w_hit = 1'b1;
      REG_STATUS: begin
        w_hit = 1'b1;
        w_rdata[BUSY_A_BIT]  = w_busy_a;
        w_rdata[DONE_A_BIT]  = w_done_a;
        w_rdata[ARMED_A_BIT] = w_armed_a;
        w_rdata[BUSY_B_BIT]  = w_busy_b;
        w_rdata[DONE_B_BIT]  = w_done_b;
        w_rdata[ARMED_B_BIT] = w_armed_b;
      end
      REG_MASK: begin
        w_hit = 1'b1;
        w_rdata[MASK_A_LSB +: DIO_WIDTH] = r_mask_a;
        w_rdata[MASK_B_LSB +: DIO_WIDTH] = r_mask_b;
      end
      REG_PERIOD_A: begin w_hit = 1'b1; w_rdata = 32'(r_period_a); end
      REG_HIGH_A:   begin w_hit = 1'b1; w_rdata = 32'(r_high_a);   end
      REG_COUNT_A:  begin w_hit = 1'b1; w_rdata = 32'(r_count_a);  end
      REG_PERIOD_B: begin w_hit = 1'b1; w_rdata = 32'(r_period_b); end
      REG_HIGH_B:   begin w_hit = 1'b1; w_rdata = 32'(r_high_b);   end
      REG_COUNT_B:  begin w_hit = 1'b1; w_rdata = 32'(r_count_b);  end
      default: ;
    endcase
  end

  // Configuration register writes.
  always_ff @(posedge ctrlport_clk or negedge ctrlport_rst_n) begin
    if (!ctrlport_rst_n) begin
      r_mask_a   <= '0;
      r_mask_b   <= '0;
      r_period_a <= '0;
      r_high_a   <= '0;
      r_count_a  <= '0;
      r_period_b <= '0;
      r_high_b   <= '0;
      r_count_b  <= '0;
    end else if (s_ctrlport.req_wr) begin
      case (w_off)
        REG_MASK: begin
          r_mask_a <= s_ctrlport.req_data[MASK_A_LSB +: DIO_WIDTH];
          r_mask_b <= s_ctrlport.req_data[MASK_B_LSB +: DIO_WIDTH];
        end
        REG_PERIOD_A: r_period_a <= s_ctrlport.req_data[CNT_W-1:0];
        REG_HIGH_A:   r_high_a   <= s_ctrlport.req_data[CNT_W-1:0];
        REG_COUNT_A:  r_count_a  <= s_ctrlport.req_data[CNT_W-1:0];
        REG_PERIOD_B: r_period_b <= s_ctrlport.req_data[CNT_W-1:0];
        REG_HIGH_B:   r_high_b   <= s_ctrlport.req_data[CNT_W-1:0];
        REG_COUNT_B:  r_count_b  <= s_ctrlport.req_data[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  // One-cycle ack for mapped addresses only.
  always_ff @(posedge ctrlport_clk or negedge ctrlport_rst_n) begin
    if (!ctrlport_rst_n) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= (s_ctrlport.req_wr | s_ctrlport.req_rd) & w_hit;
      r_rdata <= (s_ctrlport.req_rd & w_hit) ? w_rdata : '0;
    end
  end

  assign s_ctrlport.resp_ack  = r_ack;
  assign s_ctrlport.resp_data = r_rdata;

  x4xx_dio_pulse_chan #(
    .DIO_WIDTH (DIO_WIDTH),
    .CNT_W     (CNT_W)
  ) u_chan_a (
    .clk      (ctrlport_clk),
    .rst_n    (ctrlport_rst_n),
    .i_start  (w_start_a),
    .i_stop   (w_stop_a),
    .i_arm    (w_arm_a),
    .i_trig   (w_trig),
    .i_period (r_period_a),
    .i_high   (r_high_a),
    .i_count  (r_count_a),
    .i_mask   (r_mask_a),
    .o_busy   (w_busy_a),
    .o_done   (w_done_a),
    .o_armed  (w_armed_a),
    .o_gpio   (gpio_out_fabric_a)
  );

  x4xx_dio_pulse_chan #(
    .DIO_WIDTH (DIO_WIDTH),
    .CNT_W     (CNT_W)
  ) u_chan_b (
    .clk      (ctrlport_clk),
    .rst_n    (ctrlport_rst_n),
    .i_start  (w_start_b),
    .i_stop   (w_stop_b),
    .i_arm    (w_arm_b),
    .i_trig   (w_trig),
    .i_period (r_period_b),
    .i_high   (r_high_b),
    .i_count  (r_count_b),
    .i_mask   (r_mask_b),
    .o_busy   (w_busy_b),
    .o_done   (w_done_b),
    .o_armed  (w_armed_b),
    .o_gpio   (gpio_out_fabric_b)
  );

  assign busy = {w_busy_b, w_busy_a};

endmodule
